load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - CPU-side initiator for the word-addressed data memory (mem_write/address/write_data/read_data, async read, write on posedge).
// - Accepts byte/half/word load and store requests from the core's MEM stage; issues word accesses.
// - Sub-word stores use read-modify-write. Sub-word loads are lane-extracted and sign- or zero-extended.
// - Misaligned, illegal-size and out-of-range requests are rejected with resp_err; the memory is not written.
// PARAMETERS
// - MEM_WORDS  256  number of 32-bit words in data memory; valid word index is addr[31:2] < MEM_WORDS
// PORTS
// - clk             in   1   system clock, all state on posedge
// - rst             in   1   asynchronous, active-high reset
// - req_valid       in   1   request present (sampled only while req_ready=1)
// - req_ready       out  1   unit idle, able to accept
// - req_we          in   1   1=store, 0=load
// - req_size        in   2   00=byte, 01=half, 10=word, 11=illegal
// - req_unsigned    in   1   loads: 1=zero-extend, 0=sign-extend
// - req_addr        in   32  byte address
// - req_wdata       in   32  store data, right-aligned (byte in [7:0], half in [15:0])
// - resp_valid      out  1   one-cycle completion pulse, no backpressure
// - resp_rdata      out  32  extended load data; 0 for stores and errors
// - resp_err        out  1   valid with resp_valid: misaligned, illegal size or out of range
// - mem_write       out  1   memory write enable
// - mem_address     out  32  word-aligned byte address {addr[31:2],2'b00}
// - mem_write_data  out  32  full merged word to write
// - mem_read_data   in   32  combinational read data for mem_address
// BEHAVIOUR
// - Reset (async): state=IDLE; req_ready=1; resp_valid/resp_err/mem_write=0; resp_rdata/mem_address/mem_write_data=0.
// - Reset mid-operation aborts the access; mem_write drops with reset; no resp_valid for the aborted request.
// - FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP. req_ready=1 only in IDLE.
// - Accept = req_valid & req_ready. Latch addr/size/we/unsigned/wdata; check the request the same cycle.
// - Error if size=11; half with addr[0]=1; word with addr[1:0]!=0; or addr[31:2]>=MEM_WORDS.
//   - On error: IDLE->RESP with resp_err=1 and rdata=0.
// - Load: IDLE->LOAD->RESP. In LOAD, extract lane addr[1:0] (half: addr[1]) from mem_read_data, extend, register.
// - Word store: IDLE->WRITE->RESP. mem_write=1 for exactly one cycle in WRITE.
// - Byte/half store: IDLE->RMW_RD->WRITE->RESP. In RMW_RD, register mem_read_data with the target lane(s) replaced.
// - mem_write is a decode of state==WRITE only. mem_address is held from the latched address for the whole op.
// - RESP: resp_valid=1 for one cycle, then IDLE. A new request can be accepted the cycle after RESP.
// - Latency from accept to resp_valid:
//   - error: 1 cycle
//   - load / word store: 2 cycles
//   - sub-word store: 3 cycles
// - resp_rdata/resp_err hold their value until the next RESP. Only resp_valid qualifies them.
// - req_* is ignored while busy; inputs that change mid-op have no effect.
// TESTING
// - Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem[4]=DEADBEEF; rdata=DEADBEEF; resp 2 cycles after accept.
// - Byte store 0xAA @0x11 over mem[4]=0x11223344 -> mem[4]=0x1122AA44; one mem_write pulse; resp 3 cycles after accept.
// - Byte load @0x11 from 0x1122AA44: signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
// - Half load @0x12 signed from 0x80001234 -> 0xFFFF8000. Half store @0x13 -> resp_err=1, memory unchanged, latency 1.
// - Word load @0x400 with MEM_WORDS=256 -> resp_err=1, rdata=0; size=11 -> resp_err=1; mem_write never asserted.
// - Assert rst during WRITE of a sub-word store -> mem_write falls immediately; no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus between the core MEM stage,
// the load/store unit and the word-addressed data memory.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   // Core and memory side
   modport master (
      output req_valid, req_we, req_size, req_unsigned,
      output req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_write, mem_address, mem_write_data
   );

   // Load/store unit side
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned,
      input  req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory,
// read-modify-write for sub-word stores, checked for alignment and range.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } state_t;

   localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

   state_t      state;
   state_t      state_next;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        bad;
   logic [4:0]  shift;
   logic [15:0] lane;
   logic [31:0] mask;
   logic [31:0] merged;
   logic [31:0] load_val;
   logic [31:0] rdata_next;
   logic        err_next;

   assign accept = bus.req_valid & bus.req_ready;
   assign shift  = {addr_q[1:0], 3'b000};
   assign lane   = 16'(bus.mem_read_data >> shift);
   assign merged = (bus.mem_read_data & ~mask) | ((word_q << shift) & mask);

   // Reject illegal size, misalignment and out-of-range word index
   always_comb begin
      bad = 1'b0;
      case (bus.req_size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = bus.req_addr[0];
         2'b10:   bad = |bus.req_addr[1:0];
         default: bad = 1'b1;
      endcase
      if ({1'b0, bus.req_addr[31:2]} >= WORD_LIMIT) begin
         bad = 1'b1;
      end
   end

   // Lane extraction with sign/zero extension, and the store lane mask
   always_comb begin
      load_val = bus.mem_read_data;
      mask     = 32'hFFFF_FFFF;
      case (size_q)
         2'b00: begin
            load_val = {{24{lane[7] & ~unsigned_q}}, lane[7:0]};
            mask     = 32'h0000_00FF << shift;
         end
         2'b01: begin
            load_val = {{16{lane[15] & ~unsigned_q}}, lane};
            mask     = 32'h0000_FFFF << shift;
         end
         default: begin
            load_val = bus.mem_read_data;
            mask     = 32'hFFFF_FFFF;
         end
      endcase
   end

   // Next-state and response-value decode
   always_comb begin
      state_next = state;
      rdata_next = 32'h0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bad) begin
                  state_next = RESP;
                  err_next   = 1'b1;
               end else if (!bus.req_we) begin
                  state_next = LOAD;
               end else if (bus.req_size == 2'b10) begin
                  state_next = WRITE;
               end else begin
                  state_next = RMW_RD;
               end
            end
         end
         LOAD: begin
            state_next = RESP;
            rdata_next = load_val;
         end
         RMW_RD:  state_next = WRITE;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latch; the data word is merged in place during RMW_RD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= 32'h0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         word_q     <= 32'h0;
      end else if (accept) begin
         addr_q     <= bus.req_addr;
         size_q     <= bus.req_size;
         unsigned_q <= bus.req_unsigned;
         word_q     <= bus.req_wdata;
      end else if (state == RMW_RD) begin
         word_q <= merged;
      end
   end

   // Response values change only when entering RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else if (state_next == RESP) begin
         rdata_q <= rdata_next;
         err_q   <= err_next;
      end
   end

   assign bus.req_ready      = (state == IDLE);
   assign bus.resp_valid     = (state == RESP);
   assign bus.mem_write      = (state == WRITE);
   assign bus.mem_address    = {addr_q[31:2], 2'b00};
   assign bus.mem_write_data = word_q;
   assign bus.resp_rdata     = rdata_q;
   assign bus.resp_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus random traffic
// against a byte-array reference memory.
module tb_load_store_unit;

   localparam int MEM_WORDS = 256;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wr_count = 0;

   logic [31:0] mem [0:255];
   logic [7:0]  ref_bytes [0:1023];

   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Data memory: async read, write on posedge
   assign bus.mem_read_data = mem[bus.mem_address[9:2]];

   always @(posedge clk) begin
      if (bus.mem_write) begin
         mem[bus.mem_address[9:2]] <= bus.mem_write_data;
         wr_count <= wr_count + 1;
      end
   end

   // Reference behaviour on a byte array
   task automatic model_op(
      input  logic        we,
      input  logic [1:0]  size,
      input  logic        uns,
      input  logic [31:0] addr,
      input  logic [31:0] wdata,
      output logic [31:0] rdata,
      output logic        err,
      output int          lat,
      output int          pulses
   );
      int          nb;
      int          base;
      logic [31:0] v;
      nb  = 1 << size;
      err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) ||
            (addr / 4 >= MEM_WORDS);
      rdata  = 32'h0;
      pulses = 0;
      if (err) begin
         lat = 1;
      end else if (we) begin
         base = int'(addr[9:0]);
         for (int i = 0; i < nb; i++) ref_bytes[base + i] = wdata[8 * i +: 8];
         lat    = (size == 2'd2) ? 2 : 3;
         pulses = 1;
      end else begin
         base = int'(addr[9:0]);
         v    = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
         if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rdata = v;
         lat   = 2;
      end
   endtask

   // Drive one request and observe its response
   task automatic do_op(
      input  logic        we,
      input  logic [1:0]  size,
      input  logic        uns,
      input  logic [31:0] addr,
      input  logic [31:0] wdata,
      output logic [31:0] rdata,
      output logic        err,
      output int          lat,
      output int          pulses,
      output logic [31:0] maddr
   );
      int w0;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      w0 = wr_count;
      @(posedge clk);
      #1;
      maddr = bus.mem_address;
      lat   = 1;
      // Garbage while busy must be ignored
      bus.req_we       = 1'($urandom);
      bus.req_size     = 2'($urandom);
      bus.req_unsigned = 1'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      while (!bus.resp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      bus.req_valid = 1'b0;
      rdata  = bus.resp_rdata;
      err    = bus.resp_err;
      pulses = wr_count - w0;
      if (!bus.resp_valid) lat = 99;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1", bus.req_ready);
      end
      n_checks++;
      if ({bus.resp_valid, bus.resp_err, bus.mem_write} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000",
                  {bus.resp_valid, bus.resp_err, bus.mem_write});
      end
      n_checks++;
      if (bus.resp_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata got %h want 0", bus.resp_rdata);
      end
      n_checks++;
      if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mem_bus got %h/%h want 0/0",
                  bus.mem_address, bus.mem_write_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0",
                  bus.req_ready, bus.resp_valid);
      end
   endtask

   task automatic test_fill();
      logic [31:0] d, r, er, ma, mr;
      logic        e, ee;
      int          l, p, el, ep, bad;
      bad = 0;
      for (int w = 0; w < MEM_WORDS; w++) begin
         d = $urandom;
         model_op(1'b1, 2'd2, 1'b0, 32'(w * 4), d, er, ee, el, ep);
         do_op(1'b1, 2'd2, 1'b0, 32'(w * 4), d, r, e, l, p, ma);
         if (e !== ee || l != el || p != ep || r !== er) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL fill_word_stores got %0d bad responses want 0", bad);
      end
   endtask

   task automatic test_word_access();
      logic [31:0] r, er, ma, held;
      logic        e, ee;
      int          l, p, el, ep;
      model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, er, ee, el, ep);
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, e, l, p, ma);
      n_checks++;
      if (l != 2 || e !== 1'b0 || p != 1 || r !== 32'h0) begin
         n_fail++;
         $display("FAIL word_store got lat=%0d err=%b wr=%0d rdata=%h want 2/0/1/0",
                  l, e, p, r);
      end
      n_checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL word_store_mem got %h want deadbeef", mem[4]);
      end
      model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'hDEADBEEF || l != 2 || e !== 1'b0 || ma !== 32'h10) begin
         n_fail++;
         $display("FAIL word_load got rdata=%h lat=%0d err=%b addr=%h want deadbeef/2/0/10",
                  r, l, e, ma);
      end
      held = r;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== held) begin
         n_fail++;
         $display("FAIL rdata_hold got valid=%b rdata=%h want 0/%h",
                  bus.resp_valid, bus.resp_rdata, held);
      end
   endtask

   task automatic test_sub_word();
      logic [31:0] r, er, ma;
      logic        e, ee;
      int          l, p, el, ep;
      model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, er, ee, el, ep);
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, r, e, l, p, ma);
      model_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, er, ee, el, ep);
      do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, r, e, l, p, ma);
      n_checks++;
      if (l != 3 || p != 1 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL byte_store got lat=%0d wr=%0d err=%b want 3/1/0", l, p, e);
      end
      n_checks++;
      if (mem[4] !== 32'h1122AA44) begin
         n_fail++;
         $display("FAIL byte_store_mem got %h want 1122aa44", mem[4]);
      end
      model_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'hFFFFFFAA || l != 2) begin
         n_fail++;
         $display("FAIL byte_load_signed got %h lat=%0d want ffffffaa/2", r, l);
      end
      model_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'h000000AA) begin
         n_fail++;
         $display("FAIL byte_load_unsigned got %h want 000000aa", r);
      end
      model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80001234, er, ee, el, ep);
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80001234, r, e, l, p, ma);
      model_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'hFFFF8000) begin
         n_fail++;
         $display("FAIL half_load_signed got %h want ffff8000", r);
      end
      model_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'h00001234) begin
         n_fail++;
         $display("FAIL half_load_unsigned got %h want 00001234", r);
      end
   endtask

   task automatic test_errors();
      logic [31:0] r, er, ma;
      logic        e, ee;
      int          l, p, el, ep, w0;
      w0 = wr_count;
      model_op(1'b1, 2'd1, 1'b0, 32'h13, 32'hBEEF, er, ee, el, ep);
      do_op(1'b1, 2'd1, 1'b0, 32'h13, 32'hBEEF, r, e, l, p, ma);
      n_checks++;
      if (e !== 1'b1 || l != 1 || r !== 32'h0) begin
         n_fail++;
         $display("FAIL misaligned_half_store got err=%b lat=%0d rdata=%h want 1/1/0",
                  e, l, r);
      end
      n_checks++;
      if (mem[4] !== 32'h80001234) begin
         n_fail++;
         $display("FAIL misaligned_mem got %h want 80001234", mem[4]);
      end
      model_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (e !== 1'b1 || r !== 32'h0 || l != 1) begin
         n_fail++;
         $display("FAIL out_of_range_load got err=%b rdata=%h lat=%0d want 1/0/1",
                  e, r, l);
      end
      model_op(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (e !== 1'b0 || r !== er) begin
         n_fail++;
         $display("FAIL last_word_load got err=%b rdata=%h want 0/%h", e, r, er);
      end
      model_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678, er, ee, el, ep);
      do_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h12345678, r, e, l, p, ma);
      n_checks++;
      if (e !== 1'b1 || l != 1) begin
         n_fail++;
         $display("FAIL illegal_size_store got err=%b lat=%0d want 1/1", e, l);
      end
      model_op(1'b1, 2'd2, 1'b0, 32'h402, 32'h1, er, ee, el, ep);
      do_op(1'b1, 2'd2, 1'b0, 32'h402, 32'h1, r, e, l, p, ma);
      n_checks++;
      if (wr_count != w0) begin
         n_fail++;
         $display("FAIL error_no_write got %0d writes want 0", wr_count - w0);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] r, er, ma;
      logic        e, ee;
      int          l, p, el, ep, seen;
      model_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, er, ee, el, ep);
      do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, r, e, l, p, ma);
      @(negedge clk);
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h12;
      bus.req_wdata    = 32'h55;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.mem_write !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_in_write got mem_write=%b want 1", bus.mem_write);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_reset got write=%b ready=%b valid=%b want 0/1/0",
                  bus.mem_write, bus.req_ready, bus.resp_valid);
      end
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid) seen++;
      end
      n_checks++;
      if (seen != 0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_no_resp got resp=%0d ready=%b want 0/1", seen, bus.req_ready);
      end
      model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, er, ee, el, ep);
      do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e, l, p, ma);
      n_checks++;
      if (r !== 32'h11223344 || r !== er) begin
         n_fail++;
         $display("FAIL abort_mem got %h want 11223344", r);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, er, ma, a, d;
      logic        e, ee, we, uns;
      logic [1:0]  sz;
      int          l, p, el, ep, k;
      for (int n = 0; n < 300; n++) begin
         k   = $urandom_range(0, 7);
         sz  = (k < 3) ? 2'd0 : (k < 5) ? 2'd1 : (k < 7) ? 2'd2 : 2'd3;
         we  = 1'($urandom);
         uns = 1'($urandom);
         d   = $urandom;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         model_op(we, sz, uns, a, d, er, ee, el, ep);
         do_op(we, sz, uns, a, d, r, e, l, p, ma);
         n_checks++;
         if (r !== er || e !== ee || l != el || p != ep || ma !== {a[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL random_op%0d we=%b sz=%0d a=%h got %h/%b/%0d/%0d/%h want %h/%b/%0d/%0d/%h",
                     n, we, sz, a, r, e, l, p, ma, er, ee, el, ep, {a[31:2], 2'b00});
         end
      end
   endtask

   task automatic test_mem_sweep();
      logic [31:0] w;
      for (int i = 0; i < MEM_WORDS; i++) begin
         w = {ref_bytes[4 * i + 3], ref_bytes[4 * i + 2], ref_bytes[4 * i + 1], ref_bytes[4 * i]};
         n_checks++;
         if (mem[i] !== w) begin
            n_fail++;
            $display("FAIL mem_sweep word %0d got %h want %h", i, mem[i], w);
         end
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      repeat (2) @(posedge clk);
      test_reset();
      test_fill();
      test_word_access();
      test_sub_word();
      test_errors();
      test_reset_abort();
      test_random();
      test_mem_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
